// File: rtl/fetch_sequencer.sv
// fetch_sequencer: credit-limited I-cache request sequencer with response FIFO and flush/drain control
// Ports: clk/rst(active-low sync)/clk_en; flush_valid/flush_adr redirect; pred_taken/pred_target next-PC hint;
//        req_valid/req_ready/req_adr cache request; resp_* cache response; out_* FIFO head to decode; stall blocks pop;
//        busy = draining or requests in flight.
module fetch_sequencer #(
  parameter int ADR_W = 32,
  parameter int INST_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              stall,
  input  logic              flush_valid,
  input  logic [ADR_W-1:0]  flush_adr,
  input  logic              pred_taken,
  input  logic [ADR_W-1:0]  pred_target,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADR_W-1:0]  req_adr,
  input  logic              resp_valid,
  input  logic [ADR_W-1:0]  resp_adr,
  input  logic [INST_W-1:0] resp_data,
  input  logic [ADR_W-1:0]  resp_pred_next,
  input  logic              resp_branch_jump,
  output logic              out_valid,
  output logic [ADR_W-1:0]  out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [ADR_W-1:0]  out_pred_next,
  output logic              out_branch_jump,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * ADR_W + INST_W + 1;
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADR_W-1:0] pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic started_q;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic flush, credit, issue, resp, push, pop;
  // started_q holds off the first request until one enabled cycle after reset release
  always_comb begin
    flush = flush_valid & clk_en;
    credit = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
    req_valid = rst & started_q & (state_q == RUN) & ~flush_valid & credit;
    issue = req_valid & req_ready & clk_en;
    resp = resp_valid & clk_en;
    out_valid = rst & (cnt_q != '0);
    push = resp & (state_q == RUN) & ~flush;
    pop = out_valid & ~stall & clk_en & ~flush;
    outst_d = outst_q + CW'(issue) - CW'(resp);
    pc_d = flush ? flush_adr : issue ? (pred_taken ? pred_target : pc_q + ADR_W'(4)) : pc_q;
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    state_d = flush ? (outst_d != '0 ? DRAIN : RUN) : (outst_d == '0 ? RUN : state_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q <= RESET_VECTOR;
      outst_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      started_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      pc_q <= pc_d;
      outst_q <= outst_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      started_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && push) begin
      assert (cnt_q != CW'(FIFO_DEPTH));
      mem_q[wr_q] <= {resp_adr, resp_data, resp_pred_next, resp_branch_jump};
    end
  end
  assign req_adr = pc_q;
  assign {out_pc, out_inst, out_pred_next, out_branch_jump} = mem_q[rd_q];
  assign busy = (state_q == DRAIN) | (outst_q != '0);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized check of fetch_sequencer against a transaction-level model
module tb_fetch_sequencer;
  localparam int DEPTH = 4;
  logic clk = 0, rst, clk_en, stall, flush_valid, pred_taken, req_valid, req_ready;
  logic resp_valid, resp_branch_jump, out_valid, out_branch_jump, busy;
  logic [31:0] flush_adr, pred_target, req_adr, resp_adr, resp_data, resp_pred_next;
  logic [31:0] out_pc, out_inst, out_pred_next;
  fetch_sequencer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .flush_valid(flush_valid),
    .flush_adr(flush_adr), .pred_taken(pred_taken), .pred_target(pred_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr),
    .resp_valid(resp_valid), .resp_adr(resp_adr), .resp_data(resp_data),
    .resp_pred_next(resp_pred_next), .resp_branch_jump(resp_branch_jump),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_pred_next(out_pred_next), .out_branch_jump(out_branch_jump), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] pn;
    logic bj;
    bit stale;
  } ent_t;
  ent_t inflight[$];
  ent_t fifo[$];
  ent_t e;
  logic [31:0] m_pc;
  bit m_started, exp_rv, m_issue, m_pop;
  int checks = 0, errors = 0, phase;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit any_stale();
    foreach (inflight[i]) if (inflight[i].stale) return 1;
    return 0;
  endfunction
  initial begin
    {clk_en, stall, flush_valid, pred_taken, req_ready, resp_valid, resp_branch_jump} = '0;
    {flush_adr, pred_target, resp_adr, resp_data, resp_pred_next} = '0;
    rst = 0;
    m_pc = 0;
    m_started = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      phase = (cyc / 400) % 4;
      rst = !(cyc < 3 || (cyc >= 2000 && cyc < 2002));
      clk_en = phase == 3 ? ($urandom_range(0, 2) != 0) : 1'b1;
      stall = phase == 0 ? 1'b0 : phase == 1 ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      flush_valid = phase == 2 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      flush_adr = $urandom & 32'hffff_fffc;
      pred_taken = $urandom_range(0, 5) == 0;
      pred_target = $urandom & 32'hffff_fffc;
      req_ready = phase == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
      resp_valid = rst && inflight.size() != 0 && (phase == 0 || $urandom_range(0, 1) == 1);
      if (resp_valid) begin
        resp_adr = inflight[0].adr;
        resp_data = inflight[0].data;
        resp_pred_next = inflight[0].pn;
        resp_branch_jump = inflight[0].bj;
      end else begin
        resp_adr = $urandom;
        resp_data = $urandom;
        resp_pred_next = $urandom;
        resp_branch_jump = 1'($urandom);
      end
      #1;
      exp_rv = rst && m_started && !any_stale() && !flush_valid && (inflight.size() + fifo.size() < DEPTH);
      chk("req_valid", 64'(req_valid), 64'(exp_rv));
      chk("req_adr", 64'(req_adr), 64'(m_pc));
      chk("busy", 64'(busy), 64'(inflight.size() != 0));
      chk("out_valid", 64'(out_valid), 64'(rst && fifo.size() != 0));
      if (rst && fifo.size() != 0) begin
        chk("out_pc", 64'(out_pc), 64'(fifo[0].adr));
        chk("out_inst", 64'(out_inst), 64'(fifo[0].data));
        chk("out_pred_next", 64'(out_pred_next), 64'(fifo[0].pn));
        chk("out_branch_jump", 64'(out_branch_jump), 64'(fifo[0].bj));
      end
      if (!rst) begin
        m_pc = 0;
        m_started = 0;
        inflight.delete();
        fifo.delete();
      end else if (clk_en) begin
        m_issue = exp_rv && req_ready;
        m_pop = fifo.size() != 0 && !stall && !flush_valid;
        if (m_pop) void'(fifo.pop_front());
        if (resp_valid) begin
          e = inflight.pop_front();
          if (!e.stale && !flush_valid) fifo.push_back(e);
        end
        if (flush_valid) begin
          fifo.delete();
          foreach (inflight[i]) inflight[i].stale = 1;
          m_pc = flush_adr;
        end else if (m_issue) begin
          e.adr = m_pc;
          e.data = $urandom;
          e.pn = $urandom;
          e.bj = 1'($urandom);
          e.stale = 0;
          inflight.push_back(e);
          m_pc = pred_taken ? pred_target : m_pc + 32'd4;
        end
        m_started = 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
